// File: rtl/k054539_host_bus.sv
// Host bus initiator for the 054539 register port: single-beat read/write with
// programmable setup/strobe/hold/recovery timing, WAIT extension and timeout.
module k054539_host_bus #(
    parameter int T_SETUP   = 1,
    parameter int T_PULSE   = 4,
    parameter int T_HOLD    = 1,
    parameter int T_RECOVER = 2,
    parameter int WAIT_MAX  = 64
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       REQ,
    input  logic       REQ_WR,
    input  logic [9:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    output logic       BUSY,
    output logic       ACK,
    output logic       ERR,
    output logic [7:0] RDATA,
    output logic [7:0] PIN_AB,
    output logic       PIN_AB09,
    output logic [7:0] PIN_DB_OUT,
    output logic       PIN_DB_OE,
    input  logic [7:0] PIN_DB_IN,
    output logic       NCS,
    output logic       NRD,
    output logic       NWR,
    input  logic       PIN_WAIT
);

    // state   | meaning
    // IDLE    | waiting for REQ, BUSY low
    // SETUP   | address/data driven, NCS high
    // CSLEAD  | NCS low one cycle before strobe
    // STROBE  | NRD/NWR low, extended while WAIT is low
    // HOLD    | strobe high, NCS still low
    // RECOVER | NCS high, bus released, ACK follows
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CSLEAD, S_STROBE, S_HOLD, S_RECOVER
    } state_t;

    localparam logic [7:0] SETUP_LD   = 8'(T_SETUP - 1);
    localparam logic [7:0] PULSE_LD   = 8'(T_PULSE - 1);
    localparam logic [7:0] HOLD_LD    = 8'(T_HOLD - 1);
    localparam logic [7:0] RECOVER_LD = 8'(T_RECOVER - 1);
    localparam logic [7:0] WAIT_LIM   = 8'(WAIT_MAX);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       wr_q, wr_d;
    logic       busy_q, busy_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] ab_q, ab_d;
    logic       ab09_q, ab09_d;
    logic [7:0] db_out_q, db_out_d;
    logic       db_oe_q, db_oe_d;
    logic       ncs_q, ncs_d;
    logic       nrd_q, nrd_d;
    logic       nwr_q, nwr_d;
    logic       wait_s1_q, wait_s1_d;
    logic       wait_s2_q, wait_s2_d;

    // Address bit 8 has no pin on the chip.
    logic unused_addr8;
    assign unused_addr8 = REQ_ADDR[8];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_cnt_d = wait_cnt_q;
        wr_d       = wr_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        ab_d       = ab_q;
        ab09_d     = ab09_q;
        db_out_d   = db_out_q;
        db_oe_d    = db_oe_q;
        ncs_d      = ncs_q;
        nrd_d      = nrd_q;
        nwr_d      = nwr_q;
        wait_s1_d  = PIN_WAIT;
        wait_s2_d  = wait_s1_q;

        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    wr_d       = REQ_WR;
                    ab_d       = REQ_ADDR[7:0];
                    ab09_d     = REQ_ADDR[9];
                    db_out_d   = REQ_WR ? REQ_WDATA : db_out_q;
                    db_oe_d    = REQ_WR;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = SETUP_LD;
                    wait_cnt_d = 8'd0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    ncs_d   = 1'b0;
                    state_d = S_CSLEAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CSLEAD: begin
                nrd_d   = wr_q;
                nwr_d   = ~wr_q;
                cnt_d   = PULSE_LD;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (wait_s2_q || (wait_cnt_q == WAIT_LIM)) begin
                    // Timeout only if the chip is still holding WAIT at the limit.
                    err_d   = ~wait_s2_q;
                    rdata_d = wr_q ? rdata_q : PIN_DB_IN;
                    nrd_d   = 1'b1;
                    nwr_d   = 1'b1;
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    ncs_d   = 1'b1;
                    db_oe_d = 1'b0;
                    cnt_d   = RECOVER_LD;
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RECOVER: begin
                if (cnt_q == 8'd0) begin
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            wait_cnt_q <= 8'd0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 8'd0;
            ab_q       <= 8'd0;
            ab09_q     <= 1'b0;
            db_out_q   <= 8'd0;
            db_oe_q    <= 1'b0;
            ncs_q      <= 1'b1;
            nrd_q      <= 1'b1;
            nwr_q      <= 1'b1;
            wait_s1_q  <= 1'b1;
            wait_s2_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_cnt_q <= wait_cnt_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            ab_q       <= ab_d;
            ab09_q     <= ab09_d;
            db_out_q   <= db_out_d;
            db_oe_q    <= db_oe_d;
            ncs_q      <= ncs_d;
            nrd_q      <= nrd_d;
            nwr_q      <= nwr_d;
            wait_s1_q  <= wait_s1_d;
            wait_s2_q  <= wait_s2_d;
        end
    end

    assign BUSY       = busy_q;
    assign ACK        = ack_q;
    assign ERR        = err_q;
    assign RDATA      = rdata_q;
    assign PIN_AB     = ab_q;
    assign PIN_AB09   = ab09_q;
    assign PIN_DB_OUT = db_out_q;
    assign PIN_DB_OE  = db_oe_q;
    assign NCS        = ncs_q;
    assign NRD        = nrd_q;
    assign NWR        = nwr_q;

endmodule
